// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one variable-latency memory port between fetch and data.
// Data has priority; fetch gets a grant after MAX_D_STREAK back-to-back data wins.
module mem_port_arbiter #(
  parameter int unsigned MAX_D_STREAK = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_ready,
  output logic [31:0] dm_rdata,
  output logic        stall_F,
  output logic        stall_M,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        err
);

  localparam int unsigned StreakW = (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;
  localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_D_STREAK);
  localparam logic [7:0] WdLast = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

  state_e              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [31:0]         mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [StreakW-1:0]  streak_q, streak_d;
  logic [7:0]          wd_q, wd_d;
  logic                err_q, err_d;

  logic busy, done, abort, fetch_due;

  assign busy      = (state_q != StIdle);
  assign done      = busy & mem_ready;
  // Completion on the last watchdog cycle takes precedence over the abort.
  assign abort     = busy & ~mem_ready & (wd_q == WdLast);
  assign fetch_due = if_req & (streak_q == StreakMax);

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    streak_d    = streak_q;
    wd_d        = wd_q;
    err_d       = err_q;
    unique case (state_q)
      StIdle: begin
        if (dm_req && !fetch_due) begin
          state_d     = StBusyD;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          wd_d        = '0;
          if (if_req && (streak_q != StreakMax)) begin
            streak_d = streak_q + StreakW'(1);
          end
        end else if (if_req) begin
          state_d     = StBusyI;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          wd_d        = '0;
          streak_d    = '0;
        end
      end
      StBusyI, StBusyD: begin
        if (done || abort) begin
          state_d   = StIdle;
          mem_req_d = 1'b0;
          err_d     = err_q | abort;
        end else begin
          wd_d = wd_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      streak_q    <= '0;
      wd_q        <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      streak_q    <= streak_d;
      wd_q        <= wd_d;
      err_q       <= err_d;
    end
  end

  // A transaction being reset away never reports completion.
  always_comb begin
    if_ready = ~rst & (state_q == StBusyI) & (done | abort);
    dm_ready = ~rst & (state_q == StBusyD) & (done | abort);
    if_rdata = (if_ready && mem_ready) ? mem_rdata : '0;
    dm_rdata = (dm_ready && mem_ready) ? mem_rdata : '0;
    stall_F  = if_req & ~if_ready;
    stall_M  = dm_req & ~dm_ready;
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = err_q;

endmodule
